sms_power_sched: RTL and testbench

Sequential, area-reduced evaluator for the GF(2^6) power-map S-boxes (y = x^EXP) that shares one combinational GF(2^6) multiplier between two requesters. It replaces a fully unrolled power-map instance where area matters more than throughput. It computes the power by left-to-right square-and-multiply, one field operation per cycle. It sits between two producer channels and one consumer channel, with a round-robin arbiter at the front and a single result register at the back.

---
 rtl/sms_power_sched.sv | 181 ++++++++++++++++++
 tb/tb_sms_power_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sms_power_sched.sv
// rtl/sms_power_sched.sv - shared-multiplier GF(2^6) power map x^EXP for two requesters
// Left-to-right square-and-multiply, one field operation per cycle, round-robin front end.
module sms_power_sched #(
    parameter int EXP = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in0_valid,
    input  logic [5:0] in0_data,
    output logic       in0_ready,
    input  logic       in1_valid,
    input  logic [5:0] in1_data,
    output logic       in1_ready,
    output logic       out_valid,
    output logic [5:0] out_data,
    output logic       out_id,
    input  logic       out_ready,
    output logic       busy
);

    generate
        if (EXP < 1 || EXP > 62) begin : g_exp_range
            $error("sms_power_sched: EXP must lie in 1..62");
        end
    endgenerate

    localparam logic [7:0] EXP_BITS = 8'(EXP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SQR,
        S_MUL,
        S_DONE
    } state_t;

    // Product modulo z^6 + z + 1; the reduction folds z^k into z^(k-5) + z^(k-6).
    function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
        logic [10:0] p;
        p = '0;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) begin
                p = p ^ (11'(a) << i);
            end
        end
        for (int k = 10; k >= 6; k--) begin
            if (p[k]) begin
                p = p ^ (11'h043 << (k - 6));
            end
        end
        return p[5:0];
    endfunction

    state_t     state_q, state_d;
    logic [5:0] base_q, base_d;
    logic [5:0] acc_q, acc_d;
    logic [2:0] bidx_q, bidx_d;
    logic       id_q, id_d;
    logic       rr_q, rr_d;
    logic       out_valid_q, out_valid_d;
    logic [5:0] out_data_q, out_data_d;
    logic       out_id_q, out_id_d;

    logic       grant;
    logic       grant_vld;
    logic [5:0] grant_data;
    logic [5:0] mul_b;
    logic [5:0] mul_p;

    always_comb begin
        grant     = 1'b0;
        grant_vld = 1'b0;
        if (state_q == S_IDLE) begin
            if (in0_valid && in1_valid) begin
                grant     = rr_q;
                grant_vld = 1'b1;
            end else if (in0_valid) begin
                grant     = 1'b0;
                grant_vld = 1'b1;
            end else if (in1_valid) begin
                grant     = 1'b1;
                grant_vld = 1'b1;
            end
        end
        grant_data = grant ? in1_data : in0_data;
    end

    assign in0_ready = grant_vld && !grant;
    assign in1_ready = grant_vld && grant;

    // Squaring and base multiplication share the one multiplier.
    assign mul_b = (state_q == S_MUL) ? base_q : acc_q;
    assign mul_p = gf_mul(acc_q, mul_b);

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        acc_d       = acc_q;
        bidx_d      = bidx_q;
        id_d        = id_q;
        rr_d        = rr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    base_d  = grant_data;
                    acc_d   = 6'd1;
                    bidx_d  = 3'd5;
                    id_d    = grant;
                    rr_d    = ~grant;
                    state_d = S_SQR;
                end
            end
            S_SQR: begin
                acc_d = mul_p;
                if (EXP_BITS[bidx_q]) begin
                    state_d = S_MUL;
                end else if (bidx_q == 3'd0) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = mul_p;
                    out_id_d    = id_q;
                end else begin
                    bidx_d = bidx_q - 3'd1;
                end
            end
            S_MUL: begin
                acc_d = mul_p;
                if (bidx_q == 3'd0) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = mul_p;
                    out_id_d    = id_q;
                end else begin
                    bidx_d  = bidx_q - 3'd1;
                    state_d = S_SQR;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            acc_q       <= '0;
            bidx_q      <= '0;
            id_q        <= 1'b0;
            rr_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            acc_q       <= acc_d;
            bidx_q      <= bidx_d;
            id_q        <= id_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sms_power_sched.sv
// tb/tb_sms_power_sched.sv - randomized self-checking bench for sms_power_sched
// Three instances (EXP = 20, 62, 7) share clock and reset; one is exercised at a time.
module tb_sms_power_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in0_valid [3];
    logic [5:0] in0_data  [3];
    logic       in0_ready [3];
    logic       in1_valid [3];
    logic [5:0] in1_data  [3];
    logic       in1_ready [3];
    logic       out_valid [3];
    logic [5:0] out_data  [3];
    logic       out_id    [3];
    logic       out_ready [3];
    logic       busy      [3];

    int n_vec = 0;
    int n_err = 0;
    int qx[$];
    int qid[$];

    function automatic int exp_of(input int k);
        case (k)
            0:       return 20;
            1:       return 62;
            default: return 7;
        endcase
    endfunction

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            sms_power_sched #(.EXP(exp_of(g))) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in0_valid (in0_valid[g]),
                .in0_data  (in0_data[g]),
                .in0_ready (in0_ready[g]),
                .in1_valid (in1_valid[g]),
                .in1_data  (in1_data[g]),
                .in1_ready (in1_ready[g]),
                .out_valid (out_valid[g]),
                .out_data  (out_data[g]),
                .out_id    (out_id[g]),
                .out_ready (out_ready[g]),
                .busy      (busy[g])
            );
        end
    endgenerate

    // Reference field arithmetic: multiply-by-z stepping and plain repeated multiplication.
    function automatic int xtime(input int a);
        int r;
        r = a << 1;
        if ((r & 'h40) != 0) r = r ^ 'h43;
        return r & 'h3f;
    endfunction

    function automatic int gmul(input int a, input int b);
        int r;
        int t;
        r = 0;
        t = a;
        for (int i = 0; i < 6; i++) begin
            if (((b >> i) & 1) != 0) r = r ^ t;
            t = xtime(t);
        end
        return r;
    endfunction

    function automatic int gpow(input int x, input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = gmul(r, x);
        return r;
    endfunction

    task automatic chk(input string tag, input integer got, input integer exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_op(input int k, input int req, input int x, input int hold, output int res);
        int cnt;
        int lat;
        int bad;
        int d0;
        int i0;
        @(negedge clk);
        out_ready[k] = (hold == 0);
        if (req == 0) begin
            in0_valid[k] = 1'b1;
            in0_data[k]  = 6'(x);
        end else begin
            in1_valid[k] = 1'b1;
            in1_data[k]  = 6'(x);
        end
        #1;
        cnt = 0;
        while (((req == 0) ? in0_ready[k] : in1_ready[k]) !== 1'b1 && cnt < 50) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        chk("accept_timeout", (cnt < 50) ? 1 : 0, 1);
        @(posedge clk);
        #1;
        in0_valid[k] = 1'b0;
        in1_valid[k] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (out_valid[k] !== 1'b1 && lat < 100);
        chk("latency", lat, 7 + $countones(exp_of(k)));
        res = int'(out_data[k]);
        chk("result", out_data[k], gpow(x, exp_of(k)));
        chk("out_id", out_id[k], req);
        if (hold > 0) begin
            d0  = int'(out_data[k]);
            i0  = int'(out_id[k]);
            bad = 0;
            in0_valid[k] = 1'b1;
            in1_valid[k] = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (out_valid[k] !== 1'b1 || int'(out_data[k]) != d0 || int'(out_id[k]) != i0 ||
                    in0_ready[k] !== 1'b0 || in1_ready[k] !== 1'b0) bad++;
            end
            chk("hold_stable", bad, 0);
            in0_valid[k] = 1'b0;
            in1_valid[k] = 1'b0;
            out_ready[k] = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        chk("return_idle", {out_valid[k], busy[k]}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int res;
        int cyc;
        int prev;
        int bad;
        int n_acc;
        int n_res;
        int hold;
        logic a0;
        logic a1;

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in0_valid[k] = 1'b0;
            in1_valid[k] = 1'b0;
            in0_data[k]  = '0;
            in1_data[k]  = '0;
            out_ready[k] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_out_valid", out_valid[k], 0);
            chk("rst_out_data", out_data[k], 0);
            chk("rst_out_id", out_id[k], 0);
            chk("rst_busy", busy[k], 0);
            chk("rst_ready", {in0_ready[k], in1_ready[k]}, 0);
        end
        in1_valid[0] = 1'b1;
        #1;
        chk("rst_grant1_only", {in0_ready[0], in1_ready[0]}, 1);
        in0_valid[0] = 1'b1;
        #1;
        chk("rst_grant_both_rr0", {in0_ready[0], in1_ready[0]}, 2);
        in0_valid[0] = 1'b0;
        in1_valid[0] = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;

        do_op(0, 0, 'h02, 0, res);
        chk("exp20_x02", res, 'h3C);
        do_op(1, 1, 'h02, 0, res);
        chk("exp62_x02", res, 'h21);
        do_op(1, 1, 'h00, 0, res);
        chk("exp62_x00", res, 'h00);
        do_op(1, 1, 'h01, 0, res);
        chk("exp62_x01", res, 'h01);

        // Both requesters valid every cycle from reset.
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        in0_data[0]  = 6'($urandom);
        in1_data[0]  = 6'($urandom);
        in0_valid[0] = 1'b1;
        in1_valid[0] = 1'b1;
        out_ready[0] = 1'b1;
        n_acc = 0;
        n_res = 0;
        prev  = -1;
        bad   = 0;
        cyc   = 0;
        while (n_res < 6 && cyc < 200) begin
            #1;
            a0 = in0_ready[0];
            a1 = in1_ready[0];
            if (busy[0] === 1'b1 && (a0 || a1)) bad++;
            if (a0 && a1) bad++;
            if (a0 || a1) begin
                chk("alt_id", a1, n_acc % 2);
                if (prev >= 0) chk("alt_gap", cyc - prev, 10);
                prev = cyc;
                n_acc++;
                qx.push_back(a1 ? int'(in1_data[0]) : int'(in0_data[0]));
                qid.push_back(a1 ? 1 : 0);
            end
            if (out_valid[0] === 1'b1) begin
                if (qx.size() == 0) begin
                    bad++;
                end else begin
                    chk("alt_result", out_data[0], gpow(qx.pop_front(), 20));
                    chk("alt_out_id", out_id[0], qid.pop_front());
                end
                n_res++;
                if (n_res == 6) begin
                    in0_valid[0] = 1'b0;
                    in1_valid[0] = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            if (a0) in0_data[0] = 6'($urandom);
            if (a1) in1_data[0] = 6'($urandom);
            @(negedge clk);
            cyc++;
        end
        chk("alt_results_seen", n_res, 6);
        chk("alt_ready_rule", bad, 0);
        @(negedge clk);

        do_op(0, 1, int'($urandom_range(0, 63)), 20, res);

        // Abort in the third SQR cycle of an EXP = 20 operation.
        @(negedge clk);
        in0_data[0]  = 6'h15;
        in0_valid[0] = 1'b1;
        #1;
        chk("rst_mid_accept", in0_ready[0], 1);
        @(posedge clk);
        #1;
        in0_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid_busy", busy[0], 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy_clr", busy[0], 0);
        chk("rst_mid_out_valid", out_valid[0], 0);
        chk("rst_mid_out_data", out_data[0], 0);
        chk("rst_mid_out_id", out_id[0], 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        in0_valid[0] = 1'b1;
        in1_valid[0] = 1'b1;
        #1;
        chk("rst_mid_rr0", {in0_ready[0], in1_ready[0]}, 2);
        in0_valid[0] = 1'b0;
        in1_valid[0] = 1'b0;
        do_op(0, 0, 'h15, 0, res);

        for (int k = 0; k < 3; k++) begin
            for (int x = 0; x < 64; x++) begin
                hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
                do_op(k, x % 2, x, hold, res);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
